// File: rtl/swc_ob_prio_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : swc_ob_prio_scheduler
// Purpose  : Per-output-port priority scheduler for the switch core output
//            block. Watches the per-priority page queues of one output port
//            and picks the next queue whose packet goes to the source fabric.
//            Packets are sequenced one at a time:
//            select -> grant handshake -> wait for end of packet.
//            The policy is strict priority with a per-priority pause mask.
//            Anti-starvation is optional.
// Config   : SWC_SCHED_STARVE_EN - when defined, adds one 8-bit saturating
//            bypass counter per queue. A queue whose counter has reached
//            g_starve_limit is served ahead of strict priority.
// Ports    : clk_i          system clock
//            rst_i          synchronous, active-high reset
//            q_not_empty_i  per-queue "holds a complete packet" flags
//            pause_i        per-queue pause mask (paused = not eligible)
//            grant_valid_o  a queue is selected (registered)
//            grant_prio_o   index of the selected queue (registered)
//            grant_ack_i    output block accepted the grant
//            pck_done_i     1-cycle pulse, last word of the packet sent
//            busy_o         high while in GRANT or BUSY (registered)
// Revision : 1.0 - initial release
// ============================================================================
module swc_ob_prio_scheduler #(
    parameter int g_prio_num     = 8,
    parameter int g_prio_width   = 3,
    parameter int g_starve_limit = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [g_prio_num-1:0]   q_not_empty_i,
    input  logic [g_prio_num-1:0]   pause_i,
    output logic                    grant_valid_o,
    output logic [g_prio_width-1:0] grant_prio_o,
    input  logic                    grant_ack_i,
    input  logic                    pck_done_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [g_prio_width-1:0] grant_prio_q, grant_prio_d;
    logic                    busy_q, busy_d;

    logic [g_prio_num-1:0]   w_eligible;
    logic                    w_any_eligible;
    logic [g_prio_width-1:0] w_sel_strict;
    logic [g_prio_width-1:0] w_sel;
    // Pulses on the GRANT->BUSY transition (grant accepted).
    logic                    w_accept;

    assign w_eligible     = q_not_empty_i & ~pause_i;
    assign w_any_eligible = |w_eligible;

    // Highest eligible index; ascending scan so the last hit wins.
    always_comb begin
        w_sel_strict = '0;
        for (int p = 0; p < g_prio_num; p++) begin
            if (w_eligible[p]) begin
                w_sel_strict = g_prio_width'(p);
            end
        end
    end

`ifdef SWC_SCHED_STARVE_EN
    localparam logic [7:0] c_starve_limit = 8'(g_starve_limit);

    logic [7:0]              starve_q [g_prio_num];
    logic [7:0]              starve_d [g_prio_num];
    logic [g_prio_num-1:0]   w_starved;
    logic [g_prio_width-1:0] w_sel_starved;

    // A starved queue is one still eligible whose counter hit the limit;
    // the highest such queue overrides strict priority.
    always_comb begin
        w_sel_starved = '0;
        for (int p = 0; p < g_prio_num; p++) begin
            w_starved[p] = w_eligible[p] && (starve_q[p] == c_starve_limit);
            if (w_starved[p]) begin
                w_sel_starved = g_prio_width'(p);
            end
        end
    end

    assign w_sel = (|w_starved) ? w_sel_starved : w_sel_strict;

    // Counters move only when a grant is accepted. Bypassed queues that
    // were eligible (not paused, not empty) at that moment count up,
    // saturating at the limit; the served queue restarts from zero.
    always_comb begin
        for (int p = 0; p < g_prio_num; p++) begin
            starve_d[p] = starve_q[p];
            if (w_accept) begin
                if (g_prio_width'(p) == grant_prio_q) begin
                    starve_d[p] = 8'd0;
                end else if (w_eligible[p] && (starve_q[p] < c_starve_limit)) begin
                    starve_d[p] = starve_q[p] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < g_prio_num; p++) begin
                starve_q[p] <= 8'd0;
            end
        end else begin
            for (int p = 0; p < g_prio_num; p++) begin
                starve_q[p] <= starve_d[p];
            end
        end
    end
`else
    assign w_sel = w_sel_strict;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_prio_d  = grant_prio_q;
        busy_d        = busy_q;
        w_accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any_eligible) begin
                    state_d       = ST_GRANT;
                    grant_prio_d  = w_sel;
                    grant_valid_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            ST_GRANT: begin
                // Ack has precedence over loss of eligibility. A newly
                // eligible higher priority does not re-target the grant.
                if (grant_ack_i) begin
                    state_d       = ST_BUSY;
                    grant_valid_d = 1'b0;
                    w_accept      = 1'b1;
                end else if (!w_eligible[grant_prio_q]) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    busy_d        = 1'b0;
                end
            end
            ST_BUSY: begin
                // No preemption: queue/pause changes are ignored here.
                if (pck_done_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_prio_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_prio_q  <= grant_prio_d;
            busy_q        <= busy_d;
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign grant_prio_o  = grant_prio_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_swc_ob_prio_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_swc_ob_prio_scheduler
// Purpose  : Directed self-checking bench for swc_ob_prio_scheduler.
//            Inputs change and outputs are sampled 1 ns after each rising
//            edge. Scenario 6 expectations follow SWC_SCHED_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swc_ob_prio_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] q_not_empty;
    logic [7:0] pause;
    logic       grant_valid;
    logic [2:0] grant_prio;
    logic       grant_ack;
    logic       pck_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    swc_ob_prio_scheduler #(
        .g_prio_num     (8),
        .g_prio_width   (3),
        .g_starve_limit (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .q_not_empty_i (q_not_empty),
        .pause_i       (pause),
        .grant_valid_o (grant_valid),
        .grant_prio_o  (grant_prio),
        .grant_ack_i   (grant_ack),
        .pck_done_i    (pck_done),
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; q_not_empty = 8'h00; pause = 8'h00;
        grant_ack = 1'b0; pck_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; q_not_empty = 8'hFF; pause = 8'h00;
        grant_ack = 1'b0; pck_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: valid=%b busy=%b, expected 0 0", i, grant_valid, busy);
            end
        end
        checks++;
        if (grant_prio !== 3'd0) begin
            errors++;
            $display("FAIL reset_prio: got %0d expected 0", grant_prio);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b prio=%0d busy=%b, expected 1 7 1", grant_valid, grant_prio, busy);
        end
    endtask

    task automatic test_strict_priority();
        do_reset();
        q_not_empty = 8'b0010_0101;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd5) begin
            errors++;
            $display("FAIL strict_first: valid=%b prio=%0d, expected 1 5", grant_valid, grant_prio);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b1 || grant_prio !== 3'd5) begin
            errors++;
            $display("FAIL strict_busy: valid=%b busy=%b prio=%0d, expected 0 1 5", grant_valid, busy, grant_prio);
        end
        pck_done = 1'b1; q_not_empty = 8'b0000_0101;
        tick();
        pck_done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL strict_done: valid=%b busy=%b, expected 0 0", grant_valid, busy);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd2) begin
            errors++;
            $display("FAIL strict_second: valid=%b prio=%0d, expected 1 2", grant_valid, grant_prio);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        pck_done = 1'b1; q_not_empty = 8'b0000_0001;
        tick();
        pck_done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd0) begin
            errors++;
            $display("FAIL strict_third: valid=%b prio=%0d, expected 1 0", grant_valid, grant_prio);
        end
    endtask

    task automatic test_pause();
        do_reset();
        q_not_empty = 8'h81; pause = 8'h80;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd0) begin
            errors++;
            $display("FAIL pause_grant: valid=%b prio=%0d, expected 1 0", grant_valid, grant_prio);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        pause = 8'h00;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b1 || grant_prio !== 3'd0) begin
            errors++;
            $display("FAIL pause_no_preempt: valid=%b busy=%b prio=%0d, expected 0 1 0", grant_valid, busy, grant_prio);
        end
        pck_done = 1'b1;
        tick();
        pck_done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd7) begin
            errors++;
            $display("FAIL pause_release: valid=%b prio=%0d, expected 1 7", grant_valid, grant_prio);
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        q_not_empty = 8'h08;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd3) begin
            errors++;
            $display("FAIL wd_grant: valid=%b prio=%0d, expected 1 3", grant_valid, grant_prio);
        end
        // Higher priority arriving while in GRANT must not re-target.
        q_not_empty = 8'h48;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd3) begin
            errors++;
            $display("FAIL wd_no_retarget: valid=%b prio=%0d, expected 1 3", grant_valid, grant_prio);
        end
        q_not_empty = 8'h00;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_drop: valid=%b busy=%b, expected 0 0", grant_valid, busy);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: valid=%b busy=%b, expected 0 0", grant_valid, busy);
        end
        q_not_empty = 8'h08;
        tick();
        q_not_empty = 8'h00; grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_ack_wins: valid=%b busy=%b, expected 0 1", grant_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_busy_hold: busy=%b, expected 1", busy);
        end
        pck_done = 1'b1;
        tick();
        pck_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_done: valid=%b busy=%b, expected 0 0", grant_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        q_not_empty = 8'h10;
        tick();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        pck_done = 1'b1;
        tick();
        pck_done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: valid=%b busy=%b, expected 0 0", grant_valid, busy);
        end
        // Stray ack while IDLE: must still land in GRANT, not BUSY.
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd4) begin
            errors++;
            $display("FAIL b2b_grant: valid=%b prio=%0d, expected 1 4", grant_valid, grant_prio);
        end
        // Stray done while in GRANT is ignored.
        pck_done = 1'b1;
        tick();
        pck_done = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || grant_prio !== 3'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: valid=%b prio=%0d busy=%b, expected 1 4 1", grant_valid, grant_prio, busy);
        end
    endtask

    task automatic test_starvation();
        logic [2:0] exp_prio;
        do_reset();
        q_not_empty = 8'h82;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef SWC_SCHED_STARVE_EN
            exp_prio = ((i % 4) == 3) ? 3'd1 : 3'd7;
`else
            exp_prio = 3'd7;
`endif
            checks++;
            if (grant_valid !== 1'b1 || grant_prio !== exp_prio) begin
                errors++;
                $display("FAIL starve_seq[%0d]: valid=%b prio=%0d, expected 1 %0d", i, grant_valid, grant_prio, exp_prio);
            end
            grant_ack = 1'b1;
            tick();
            grant_ack = 1'b0;
            pck_done = 1'b1;
            tick();
            pck_done = 1'b0;
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        q_not_empty = 8'h04;
        tick();
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0 || grant_prio !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b prio=%0d, expected 0 0 0", grant_valid, busy, grant_prio);
        end
    endtask

    initial begin
        test_reset();
        test_strict_priority();
        test_pause();
        test_withdrawal();
        test_back_to_back();
        test_starvation();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
